unified_cache_mem_responder: RTL and testbench

//  Memory-side endpoint of the unified cache to_mem/from_mem packet interface.
//  - Accepts one miss or writeback packet at a time from the cache's to-mem arbiter.
//  - Services it against an internal word-addressed backing array after a fixed latency.
//  - Returns a fill packet on the from_mem channel.
//  - Serves as the main-memory model for cache integration benches and FPGA bring-up.

---
 rtl/unified_cache_mem_responder_if.sv | 50 +++++
 rtl/unified_cache_mem_responder.sv | 124 ++++++++++++
 tb/tb_unified_cache_mem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/unified_cache_mem_responder_if.sv
// unified_cache_mem_responder_if
//   to_mem / from_mem packet channel between the unified cache and its
//   memory-side responder. Also provides default packet field positions when
//   the cache parameter header has not already defined them.
//   Layout: [67] valid, [66] is_write, [65:64] port number,
//           [63:32] address, [31:0] data.

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 68
`endif
`ifndef UNIFIED_CACHE_PACKET_DATA_POS_LO
`define UNIFIED_CACHE_PACKET_DATA_POS_LO 0
`endif
`ifndef UNIFIED_CACHE_PACKET_ADDR_POS_LO
`define UNIFIED_CACHE_PACKET_ADDR_POS_LO 32
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_NUM_LO
`define UNIFIED_CACHE_PACKET_PORT_NUM_LO 64
`endif
`ifndef UNIFIED_CACHE_PACKET_IS_WRITE_POS
`define UNIFIED_CACHE_PACKET_IS_WRITE_POS 66
`endif
`ifndef UNIFIED_CACHE_PACKET_VALID_POS
`define UNIFIED_CACHE_PACKET_VALID_POS 67
`endif

interface unified_cache_mem_responder_if #(
    parameter int PW = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
);
    logic [PW-1:0] to_mem_packet_in;
    logic          to_mem_packet_ack_out;
    logic [PW-1:0] from_mem_packet_out;
    logic          from_mem_packet_ack_in;

    // Cache side: issues requests, consumes fills.
    modport master (
        output to_mem_packet_in,
        input  to_mem_packet_ack_out,
        input  from_mem_packet_out,
        output from_mem_packet_ack_in
    );

    // Memory side: consumes requests, issues fills.
    modport slave (
        input  to_mem_packet_in,
        output to_mem_packet_ack_out,
        output from_mem_packet_out,
        input  from_mem_packet_ack_in
    );
endinterface

// File: rtl/unified_cache_mem_responder.sv
// unified_cache_mem_responder
//   Memory-side endpoint of the unified cache packet interface. Accepts one
//   request at a time, services it against a word-per-block backing array
//   after ACCESS_LATENCY cycles and returns a fill packet on from_mem.
//   Optional feature macro: UNIFIED_CACHE_MEM_WRITE_RESP_EN
//     defined   -> writes are also answered (latched packet, valid=1)
//     undefined -> writes complete silently

module unified_cache_mem_responder #(
    parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
    parameter int BLOCK_SIZE_IN_BYTES                = 4,
    parameter int NUM_BLOCK                          = 1024,
    parameter int ACCESS_LATENCY                     = 4
) (
    input  logic                            clk_in,
    input  logic                            reset_in,
    unified_cache_mem_responder_if.slave    mem_if
);
    localparam int PW      = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
    localparam int DW      = BLOCK_SIZE_IN_BYTES * 8;
    localparam int OFF     = $clog2(BLOCK_SIZE_IN_BYTES);
    localparam int IW      = $clog2(NUM_BLOCK);
    localparam int CW      = $clog2(ACCESS_LATENCY + 1);
    localparam int DATA_LO = `UNIFIED_CACHE_PACKET_DATA_POS_LO;
    localparam int ADDR_LO = `UNIFIED_CACHE_PACKET_ADDR_POS_LO;
    localparam int WR_POS  = `UNIFIED_CACHE_PACKET_IS_WRITE_POS;
    localparam int VLD_POS = `UNIFIED_CACHE_PACKET_VALID_POS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic            ack_q;
    logic [PW-1:0]   req_q;
    logic [PW-1:0]   resp_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   mem_q [NUM_BLOCK];

    logic            accept_d;
    logic            accept_wr_d;
    logic [IW-1:0]   acc_idx;
    logic [IW-1:0]   rd_idx;
    logic [PW-1:0]   resp_fill_d;

    // Block index = address >> log2(block bytes); upper bits dropped so
    // out-of-range addresses wrap onto the array.
    assign acc_idx = mem_if.to_mem_packet_in[ADDR_LO + OFF +: IW];
    assign rd_idx  = req_q[ADDR_LO + OFF +: IW];

    // Only IDLE consumes a request; writes commit on the accepting edge.
    assign accept_d    = (state_q == ST_IDLE) && mem_if.to_mem_packet_in[VLD_POS];
    assign accept_wr_d = accept_d && mem_if.to_mem_packet_in[WR_POS] && !reset_in;

    // Read fill: latched request with its data field replaced by the array word.
    always_comb begin
        resp_fill_d = req_q;
        resp_fill_d[DATA_LO +: DW] = mem_q[rd_idx];
        resp_fill_d[VLD_POS] = 1'b1;
    end

    // Backing array write port; contents deliberately survive reset.
    always_ff @(posedge clk_in) begin
        if (accept_wr_d) begin
            mem_q[acc_idx] <= mem_if.to_mem_packet_in[DATA_LO +: DW];
        end
    end

    // Request/latency/response FSM with registered handshake outputs.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            req_q   <= {PW{1'b0}};
            resp_q  <= {PW{1'b0}};
            cnt_q   <= {CW{1'b0}};
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        req_q   <= mem_if.to_mem_packet_in;
                        ack_q   <= 1'b1;
                        cnt_q   <= CW'(ACCESS_LATENCY - 1);
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == {CW{1'b0}}) begin
                        if (req_q[WR_POS]) begin
`ifdef UNIFIED_CACHE_MEM_WRITE_RESP_EN
                            // Echo the write back; data field already holds written data.
                            resp_q  <= req_q;
                            state_q <= ST_RESP;
`else
                            state_q <= ST_IDLE;
`endif
                        end else begin
                            resp_q  <= resp_fill_d;
                            state_q <= ST_RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (mem_if.from_mem_packet_ack_in) begin
                        resp_q  <= {PW{1'b0}};
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_if.to_mem_packet_ack_out = ack_q;
    assign mem_if.from_mem_packet_out   = resp_q;

endmodule

// File: tb/tb_unified_cache_mem_responder.sv
// tb_unified_cache_mem_responder
//   Directed bench for the unified cache memory responder: reset, write/read
//   round trip with latency, backpressure, address wrap, reset mid-flight and
//   write-response behaviour (both settings of UNIFIED_CACHE_MEM_WRITE_RESP_EN).

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 68
`endif
`ifndef UNIFIED_CACHE_PACKET_DATA_POS_LO
`define UNIFIED_CACHE_PACKET_DATA_POS_LO 0
`endif
`ifndef UNIFIED_CACHE_PACKET_ADDR_POS_LO
`define UNIFIED_CACHE_PACKET_ADDR_POS_LO 32
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_NUM_LO
`define UNIFIED_CACHE_PACKET_PORT_NUM_LO 64
`endif
`ifndef UNIFIED_CACHE_PACKET_IS_WRITE_POS
`define UNIFIED_CACHE_PACKET_IS_WRITE_POS 66
`endif
`ifndef UNIFIED_CACHE_PACKET_VALID_POS
`define UNIFIED_CACHE_PACKET_VALID_POS 67
`endif

module tb_unified_cache_mem_responder;
    localparam int PW      = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
    localparam int LAT     = 4;
    localparam int NB      = 1024;
    localparam int DATA_LO = `UNIFIED_CACHE_PACKET_DATA_POS_LO;
    localparam int ADDR_LO = `UNIFIED_CACHE_PACKET_ADDR_POS_LO;
    localparam int PORT_LO = `UNIFIED_CACHE_PACKET_PORT_NUM_LO;
    localparam int WR_POS  = `UNIFIED_CACHE_PACKET_IS_WRITE_POS;
    localparam int VLD_POS = `UNIFIED_CACHE_PACKET_VALID_POS;

    logic clk_in   = 1'b0;
    logic reset_in = 1'b0;
    int   n_total  = 0;
    int   n_bad    = 0;

    unified_cache_mem_responder_if mem_if ();

    unified_cache_mem_responder #(
        .UNIFIED_CACHE_PACKET_WIDTH_IN_BITS(PW),
        .BLOCK_SIZE_IN_BYTES(4),
        .NUM_BLOCK(NB),
        .ACCESS_LATENCY(LAT)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .mem_if(mem_if.slave)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk_pkt(input logic wr, input logic [1:0] port,
                                             input logic [31:0] addr, input logic [31:0] data);
        logic [PW-1:0] p;
        p = '0;
        p[VLD_POS] = 1'b1;
        p[WR_POS] = wr;
        p[PORT_LO +: 2] = port;
        p[ADDR_LO +: 32] = addr;
        p[DATA_LO +: 32] = data;
        return p;
    endfunction

    function automatic logic [PW-1:0] exp_fill(input logic [PW-1:0] req, input logic [31:0] data);
        logic [PW-1:0] p;
        p = req;
        p[DATA_LO +: 32] = data;
        p[VLD_POS] = 1'b1;
        return p;
    endfunction

    // All tasks start and end 1 time unit after a rising clock edge.
    task automatic start_req(input logic [PW-1:0] pkt);
        mem_if.to_mem_packet_in = pkt;
        @(posedge clk_in); #1;
        chk("req_ack", {127'd0, mem_if.to_mem_packet_ack_out}, 128'd1);
        mem_if.to_mem_packet_in = '0;
    endtask

    // Counts edges after the accepting edge until valid appears (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (mem_if.from_mem_packet_out[VLD_POS] !== 1'b1 && lat < 40) begin
            @(posedge clk_in); #1;
            lat++;
            if (lat == 1) chk("ack_pulse", {127'd0, mem_if.to_mem_packet_ack_out}, 128'd0);
        end
    endtask

    task automatic finish_read(input logic [PW-1:0] req, input logic [31:0] data);
        int lat;
        wait_valid(lat);
        chk("rd_lat", lat, LAT);
        chk("rd_pkt", mem_if.from_mem_packet_out, exp_fill(req, data));
        mem_if.from_mem_packet_ack_in = 1'b1;
        @(posedge clk_in); #1;
        mem_if.from_mem_packet_ack_in = 1'b0;
        chk("rd_clr", mem_if.from_mem_packet_out, 128'd0);
    endtask

    task automatic do_write(input logic [PW-1:0] pkt);
        start_req(pkt);
`ifdef UNIFIED_CACHE_MEM_WRITE_RESP_EN
        begin
            int lat;
            wait_valid(lat);
            chk("wr_lat", lat, LAT);
            chk("wr_resp", mem_if.from_mem_packet_out, pkt);
            chk("wr_port", mem_if.from_mem_packet_out[PORT_LO +: 2], pkt[PORT_LO +: 2]);
            mem_if.from_mem_packet_ack_in = 1'b1;
            @(posedge clk_in); #1;
            mem_if.from_mem_packet_ack_in = 1'b0;
            chk("wr_clr", mem_if.from_mem_packet_out, 128'd0);
        end
`else
        for (int j = 1; j <= LAT; j++) begin
            @(posedge clk_in); #1;
            if (j == 1) chk("wr_ack_pulse", {127'd0, mem_if.to_mem_packet_ack_out}, 128'd0);
            chk("wr_noresp", mem_if.from_mem_packet_out, 128'd0);
        end
`endif
    endtask

    task automatic pulse_reset();
        #2;
        reset_in = 1'b1;
        mem_if.to_mem_packet_in = '0;
        mem_if.from_mem_packet_ack_in = 1'b0;
        #1;
        chk("rst_ack", {127'd0, mem_if.to_mem_packet_ack_out}, 128'd0);
        chk("rst_pkt", mem_if.from_mem_packet_out, 128'd0);
        @(posedge clk_in);
        @(posedge clk_in); #1;
        reset_in = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] rd_a;
        logic [PW-1:0] rd_b;
        int lat;
        mem_if.to_mem_packet_in = '0;
        mem_if.from_mem_packet_ack_in = 1'b0;

        // Reset state
        pulse_reset();

        // Write 0x40 from port 1 (silent or echoed depending on macro), then read back
        do_write(mk_pkt(1'b1, 2'd1, 32'h40, 32'hDEADBEEF));
        rd_a = mk_pkt(1'b0, 2'd1, 32'h40, 32'hFFFF0000);
        start_req(rd_a);
        finish_read(rd_a, 32'hDEADBEEF);

        // Wrap: block NUM_BLOCK+3 (addr 0x100C) aliases block 3 (addr 0xC)
        do_write(mk_pkt(1'b1, 2'd2, 32'h100C, 32'h1));
        rd_b = mk_pkt(1'b0, 2'd2, 32'hC, 32'h12345678);
        start_req(rd_b);
        finish_read(rd_b, 32'h1);

        // Ack held high during BUSY must be ignored
        start_req(rd_a);
        mem_if.from_mem_packet_ack_in = 1'b1;
        finish_read(rd_a, 32'hDEADBEEF);

        // Backpressure with a second request pending
        rd_a = mk_pkt(1'b0, 2'd3, 32'h40, 32'h0);
        rd_b = mk_pkt(1'b0, 2'd0, 32'hC, 32'hAAAA5555);
        start_req(rd_a);
        wait_valid(lat);
        chk("bp_lat", lat, LAT);
        mem_if.to_mem_packet_in = rd_b;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in); #1;
            chk("bp_hold", mem_if.from_mem_packet_out, exp_fill(rd_a, 32'hDEADBEEF));
            chk("bp_noack", {127'd0, mem_if.to_mem_packet_ack_out}, 128'd0);
        end
        mem_if.from_mem_packet_ack_in = 1'b1;
        @(posedge clk_in); #1;
        mem_if.from_mem_packet_ack_in = 1'b0;
        chk("bp_clr", mem_if.from_mem_packet_out, 128'd0);
        chk("bp_noack2", {127'd0, mem_if.to_mem_packet_ack_out}, 128'd0);
        @(posedge clk_in); #1;
        chk("bp_ack2", {127'd0, mem_if.to_mem_packet_ack_out}, 128'd1);
        mem_if.to_mem_packet_in = '0;
        finish_read(rd_b, 32'h1);

        // Reset while BUSY on a read of 0x80: request dropped
        start_req(mk_pkt(1'b0, 2'd0, 32'h80, 32'h0));
        @(posedge clk_in); #1;
        pulse_reset();
        for (int i = 0; i < LAT + 3; i++) begin
            @(posedge clk_in); #1;
            chk("rst_noresp", mem_if.from_mem_packet_out, 128'd0);
        end

        // Write committed at accept survives a reset mid-BUSY
        start_req(mk_pkt(1'b1, 2'd1, 32'h80, 32'hCAFEF00D));
        pulse_reset();
        rd_a = mk_pkt(1'b0, 2'd1, 32'h80, 32'h0);
        start_req(rd_a);
        finish_read(rd_a, 32'hCAFEF00D);

        // Reset while a response is held clears it asynchronously
        rd_a = mk_pkt(1'b0, 2'd2, 32'h40, 32'h0);
        start_req(rd_a);
        wait_valid(lat);
        chk("resp_before_rst", mem_if.from_mem_packet_out[VLD_POS], 1'b1);
        pulse_reset();
        start_req(rd_a);
        finish_read(rd_a, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
